// File: rtl/uart_line_buffer_if.sv
// Character-stream input and line-stream output of the UART line buffer.
// The slave modport is the buffer itself; master is the receiver/consumer side.
interface uart_line_buffer_if #(
   parameter int DATA_W = 8
);
   logic              rx_rdy;
   logic              rx_err;
   logic [31:0]       rx_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_err;
   logic              out_trunc;
   logic [15:0]       err_cnt;
   logic [15:0]       drop_cnt;
   logic [15:0]       line_cnt;

   modport slave (
      input  rx_rdy, rx_err, rx_data, flush, out_ready,
      output out_valid, out_data, out_last, out_err, out_trunc,
      output err_cnt, drop_cnt, line_cnt
   );

   modport master (
      output rx_rdy, rx_err, rx_data, flush, out_ready,
      input  out_valid, out_data, out_last, out_err, out_trunc,
      input  err_cnt, drop_cnt, line_cnt
   );
endinterface

// File: rtl/uart_line_buffer.sv
// Collects received characters into a line (ended by LF, full buffer or flush)
// and streams the line out over valid/ready, keeping error/drop/line statistics.
module uart_line_buffer #(
   parameter int DEPTH  = 80,
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   uart_line_buffer_if.slave   bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [DATA_W-1:0] CH_LF = DATA_W'(8'h0A);
   localparam logic [DATA_W-1:0] CH_CR = DATA_W'(8'h0D);
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              line_err_q, line_err_d;
   logic              trunc_q, trunc_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic [15:0]       line_cnt_q, line_cnt_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] rx_char;
   logic              is_lf;
   logic              is_cr;
   logic              store;
   logic              last_beat;
   logic [CW-1:0]     count_inc;
   logic              unused_rx_hi;

   assign rx_char      = bus.rx_data[DATA_W-1:0];
   assign unused_rx_hi = ^bus.rx_data[31:DATA_W];
   assign is_lf        = (rx_char == CH_LF);
   assign is_cr        = (rx_char == CH_CR);
   assign count_inc    = count_q + CW'(1);
   assign store        = (state_q == FILL) && bus.rx_rdy && !bus.rx_err && !is_cr;
   assign last_beat    = (CW'(rd_ptr_q) == (count_q - CW'(1)));

   // NOTE: line storage has no reset; count_q alone decides which entries are live,
   // so the array can map onto plain RAM without a reset network.
   always_ff @(posedge clk) begin
      if (store) begin
         mem[count_q[PW-1:0]] <= rx_char;
      end
   end

   // NOTE: every register in a clocked block takes a non-blocking assignment so all
   // of them update together from the values present before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FILL;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         line_err_q <= 1'b0;
         trunc_q    <= 1'b0;
         err_cnt_q  <= '0;
         drop_cnt_q <= '0;
         line_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         line_err_q <= line_err_d;
         trunc_q    <= trunc_d;
         err_cnt_q  <= err_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         line_cnt_q <= line_cnt_d;
      end
   end

   // NOTE: each next-state value is defaulted to its current value before the case
   // statement, so no path through the block leaves a signal unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      line_err_d = line_err_q;
      trunc_d    = trunc_q;
      err_cnt_d  = err_cnt_q;
      drop_cnt_d = drop_cnt_q;
      line_cnt_d = line_cnt_q;

      // Framing errors are counted in either state.
      if (bus.rx_rdy && bus.rx_err && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end

      unique case (state_q)
         FILL: begin
            if (bus.rx_rdy && bus.rx_err) begin
               line_err_d = 1'b1;
            end
            if (store) begin
               count_d = count_inc;
               if (is_lf) begin
                  state_d = DRAIN;
               end else if (count_inc == CW'(DEPTH)) begin
                  trunc_d = 1'b1;
                  state_d = DRAIN;
               end
            end
            // A flush only ends a line that actually holds characters.
            if (bus.flush && ((count_q != '0) || store)) begin
               state_d = DRAIN;
            end
         end

         DRAIN: begin
            if (bus.rx_rdy && (drop_cnt_q != CNT_MAX)) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
            if (bus.out_ready) begin
               if (last_beat) begin
                  state_d    = FILL;
                  count_d    = '0;
                  rd_ptr_d   = '0;
                  line_err_d = 1'b0;
                  trunc_d    = 1'b0;
                  line_cnt_d = line_cnt_q + 16'd1;
               end else begin
                  rd_ptr_d = rd_ptr_q + PW'(1);
               end
            end
         end

         default: state_d = FILL;
      endcase
   end

   // Outputs decode from registered state only, so they follow reset asynchronously.
   assign bus.out_valid = (state_q == DRAIN);
   assign bus.out_data  = (state_q == DRAIN) ? mem[rd_ptr_q] : '0;
   assign bus.out_last  = (state_q == DRAIN) && last_beat;
   assign bus.out_err   = (state_q == DRAIN) && line_err_q;
   assign bus.out_trunc = (state_q == DRAIN) && trunc_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.drop_cnt  = drop_cnt_q;
   assign bus.line_cnt  = line_cnt_q;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Self-checking bench for uart_line_buffer (DEPTH=4): a strobe table with a line
// model feeding a scoreboard, plus hold, drop and reset-mid-drain sequences.
module tb_uart_line_buffer;
   localparam int DEPTH  = 4;
   localparam int DATA_W = 8;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       err;
      logic       trunc;
   } beat_t;

   typedef struct {
      bit         rdy;
      bit         err;
      bit         fl;
      logic [7:0] ch;
      logic [15:0] exp_err_cnt;
   } rx_vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   uart_line_buffer_if #(.DATA_W(DATA_W)) bus ();

   uart_line_buffer #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   beat_t      sb[$];
   logic [7:0] m_line[$];
   bit         m_err = 1'b0;
   int         m_err_cnt = 0;
   int         m_line_cnt = 0;
   rx_vec_t    vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every accepted beat is compared against the oldest expected beat.
   always @(negedge clk) begin
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h, expected no beat", bus.out_data);
         end else begin
            beat_t exp_b;
            exp_b = sb.pop_front();
            check("beat_data",  bus.out_data,  exp_b.data);
            check("beat_last",  bus.out_last,  exp_b.last);
            check("beat_err",   bus.out_err,   exp_b.err);
            check("beat_trunc", bus.out_trunc, exp_b.trunc);
         end
      end
   end

   function automatic rx_vec_t vec(bit rdy, bit err, bit fl, logic [7:0] ch, logic [15:0] ec);
      rx_vec_t v;
      v.rdy = rdy; v.err = err; v.fl = fl; v.ch = ch; v.exp_err_cnt = ec;
      return v;
   endfunction

   task automatic wait_drain();
      bit done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (sb.size() == 0 && !bus.out_valid) begin
            done = 1'b1;
            break;
         end
      end
      check("drain_done", done, 1);
   endtask

   // Drive one FILL-state cycle and update the line model; completed lines go to the scoreboard.
   task automatic apply(input bit rdy, input bit err, input bit fl, input logic [7:0] ch,
                        input bit do_wait);
      bit line_end = 1'b0;
      bit trunc = 1'b0;
      bus.rx_rdy  = rdy;
      bus.rx_err  = err;
      bus.rx_data = {24'h0, ch};
      bus.flush   = fl;
      if (rdy) begin
         if (err) begin
            m_err = 1'b1;
            m_err_cnt++;
         end else if (ch != 8'h0D) begin
            m_line.push_back(ch);
            if (ch == 8'h0A) line_end = 1'b1;
            else if (m_line.size() == DEPTH) begin
               line_end = 1'b1;
               trunc = 1'b1;
            end
         end
      end
      if (fl && m_line.size() > 0) line_end = 1'b1;
      if (line_end) begin
         foreach (m_line[i]) begin
            sb.push_back('{data: m_line[i], last: (i == m_line.size() - 1), err: m_err, trunc: trunc});
         end
         m_line.delete();
         m_err = 1'b0;
         m_line_cnt++;
      end
      @(posedge clk); #1;
      bus.rx_rdy = 1'b0;
      bus.rx_err = 1'b0;
      bus.flush  = 1'b0;
      check("valid_after_strobe", bus.out_valid, line_end);
      if (line_end && do_wait) wait_drain();
   endtask

   initial begin
      vecs.push_back(vec(1, 0, 0, "H",   0));
      vecs.push_back(vec(1, 0, 0, "I",   0));
      vecs.push_back(vec(1, 0, 0, 8'h0A, 0));
      vecs.push_back(vec(1, 0, 0, "A",   0));
      vecs.push_back(vec(1, 0, 0, 8'h0D, 0));
      vecs.push_back(vec(1, 0, 0, 8'h0A, 0));
      vecs.push_back(vec(1, 0, 0, "a",   0));
      vecs.push_back(vec(1, 0, 0, "b",   0));
      vecs.push_back(vec(1, 0, 0, "c",   0));
      vecs.push_back(vec(1, 0, 0, "d",   0));
      vecs.push_back(vec(1, 0, 0, "X",   0));
      vecs.push_back(vec(1, 1, 0, 8'h55, 1));
      vecs.push_back(vec(1, 0, 0, 8'h0A, 1));
      vecs.push_back(vec(1, 0, 0, 8'h0A, 1));
      vecs.push_back(vec(1, 0, 0, "a",   1));
      vecs.push_back(vec(1, 0, 0, "b",   1));
      vecs.push_back(vec(1, 0, 0, "c",   1));
      vecs.push_back(vec(1, 0, 0, 8'h0A, 1));
      vecs.push_back(vec(1, 1, 0, 8'h33, 2));
      vecs.push_back(vec(0, 0, 1, 8'h00, 2));
      vecs.push_back(vec(1, 0, 0, "Z",   2));
      vecs.push_back(vec(1, 0, 0, 8'h0A, 2));
      vecs.push_back(vec(1, 0, 0, "Q",   2));
      vecs.push_back(vec(0, 0, 1, 8'h00, 2));
      vecs.push_back(vec(1, 0, 1, "R",   2));

      bus.rx_rdy = 1'b0; bus.rx_err = 1'b0; bus.rx_data = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b1;

      #1 rst_n = 1'b0;
      #1;
      check("rst_valid",    bus.out_valid, 0);
      check("rst_data",     bus.out_data,  0);
      check("rst_last",     bus.out_last,  0);
      check("rst_err_cnt",  bus.err_cnt,   0);
      check("rst_drop_cnt", bus.drop_cnt,  0);
      check("rst_line_cnt", bus.line_cnt,  0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         apply(vecs[i].rdy, vecs[i].err, vecs[i].fl, vecs[i].ch, 1'b1);
         check("table_err_cnt", bus.err_cnt, vecs[i].exp_err_cnt);
      end
      check("table_line_cnt", bus.line_cnt, 9);

      // Held output while the consumer stalls; CR is stripped.
      bus.out_ready = 1'b0;
      apply(1, 0, 0, "A",   1'b0);
      apply(1, 0, 0, 8'h0D, 1'b0);
      apply(1, 0, 0, 8'h0A, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_valid", bus.out_valid, 1);
         check("hold_data",  bus.out_data,  8'h41);
         check("hold_last",  bus.out_last,  0);
      end
      bus.out_ready = 1'b1;
      wait_drain();
      check("hold_line_cnt", bus.line_cnt, m_line_cnt);

      // Strobes during a stalled drain, then one on the final-transfer cycle.
      bus.out_ready = 1'b0;
      apply(1, 0, 0, "M",   1'b0);
      apply(1, 0, 0, 8'h0A, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.rx_rdy = 1'b1;
         bus.rx_err = (i == 1);
         bus.rx_data = 32'h78;
         @(posedge clk); #1;
      end
      bus.rx_rdy = 1'b0; bus.rx_err = 1'b0;
      m_err_cnt++;
      check("drop_cnt_3",   bus.drop_cnt, 3);
      check("drop_err_cnt", bus.err_cnt,  m_err_cnt);
      check("drop_data",    bus.out_data, 8'h4D);
      check("drop_valid",   bus.out_valid, 1);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("drop_last_shown", bus.out_last, 1);
      bus.rx_rdy = 1'b1; bus.rx_data = 32'h6B;
      @(posedge clk); #1;
      bus.rx_rdy = 1'b0;
      check("drop_cnt_4",     bus.drop_cnt,  4);
      check("drop_valid_off", bus.out_valid, 0);
      check("drop_line_cnt",  bus.line_cnt,  m_line_cnt);
      apply(1, 0, 0, 8'h0A, 1'b1);
      check("lf_only_line_cnt", bus.line_cnt, m_line_cnt);

      // Reset in the middle of a drain.
      bus.out_ready = 1'b0;
      apply(1, 0, 0, "P",   1'b0);
      apply(1, 0, 0, 8'h0A, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid",    bus.out_valid, 0);
      check("mid_rst_data",     bus.out_data,  0);
      check("mid_rst_err_cnt",  bus.err_cnt,   0);
      check("mid_rst_drop_cnt", bus.drop_cnt,  0);
      check("mid_rst_line_cnt", bus.line_cnt,  0);
      sb.delete();
      m_line.delete();
      m_err = 1'b0;
      m_err_cnt = 0;
      m_line_cnt = 0;
      @(negedge clk) rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      apply(1, 0, 0, "O",   1'b1);
      apply(1, 0, 0, "K",   1'b1);
      apply(1, 0, 0, 8'h0A, 1'b1);
      check("post_rst_line_cnt", bus.line_cnt, 1);
      check("post_rst_err_cnt",  bus.err_cnt,  0);
      check("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
